vm_multi: RTL and testbench
===========================

# vm_multi

Parametrised multi-slot vending-machine controller, the next generation of the single-product vending machine. It accumulates credit and holds a per-slot price and stock table that is loaded in maintenance mode. It checks each selection for range, stock and credit, vends, and returns change. It sits between the coin/keypad front end and the dispenser/refund actuators, with all sequencing in one clock domain.

## Interface
- VAL_W, 10, width of money values (deposit, price, balance, change)
- SEL_W, 5, width of product select code
- NSLOT, 8, number of product slots; must be ≤ 2**SEL_W
- STOCK_W, 4, width of per-slot stock counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- deposit  in  VAL_W  value of coin/note, sampled when deposited=1
- deposited  in  1  one-cycle strobe, deposit valid
- select  in  SEL_W  product code, sampled when selected=1
- selected  in  1  one-cycle strobe, select valid
- cancel  in  1  abort transaction, return full balance
- maintenance  in  1  level; request/hold maintenance mode
- cfg_we  in  1  table write strobe, honoured only in MAINT
- cfg_slot  in  SEL_W  slot to write
- cfg_price  in  VAL_W  price to write
- cfg_stock  in  STOCK_W  stock to write
- product  out  SEL_W  vended slot code, valid while vend=1
- vend  out  1  one-cycle dispense pulse
- balance  out  VAL_W  current credit
- refund  out  1  one-cycle change-return pulse
- change  out  VAL_W  amount returned, valid while refund=1
- reject  out  1  one-cycle pulse: deposit refused (overflow or not accepting)
- soldout  out  1  one-cycle pulse: bad slot or stock=0
- short  out  1  one-cycle pulse: balance < price
- state  out  3  current FSM state encoding

## Operation
- States and encodings: IDLE=0, CREDIT=1, CHECK=2, VEND=3, CHANGE=4, MAINT=5; codes 6–7 recover to IDLE next cycle.
- IDLE, balance=0:
  - maintenance=1 → MAINT.
  - Otherwise, deposited → balance=deposit, CREDIT.
  - selected and cancel are ignored.
- CREDIT: priority is cancel > selected > deposited.
  - cancel → CHANGE.
  - selected → latch select, CHECK.
  - deposited → balance+=deposit.
  - If the sum overflows 2**VAL_W-1, pulse reject; balance is unchanged.
- CHECK, single cycle; first matching rule applies:
  - Latched select ≥ NSLOT or stock[sel]=0 → soldout, back to CREDIT.
  - Balance < price[sel] → short, back to CREDIT.
  - Otherwise balance−=price[sel], stock[sel]−=1, → VEND.
- VEND: vend=1, product=latched select; then → CHANGE if balance≠0, else IDLE.
- CHANGE: refund=1, change=balance, balance←0, → IDLE.
- MAINT:
  - cfg_we writes price[cfg_slot] and stock[cfg_slot] in the same cycle.
  - Writes with cfg_slot ≥ NSLOT are dropped.
  - maintenance=0 → IDLE.
  - Deposits in MAINT are ignored and pulse reject.
  - Maintenance is entered only from IDLE.
- Any deposited strobe in CHECK, VEND or CHANGE pulses reject.
- Arithmetic: all money is unsigned VAL_W. Subtraction occurs only after the ≥ compare, so it never wraps. Stock never decrements below 0.

## Timing
- Reset values: state=IDLE, balance=0, change=0, product=0, and all pulses 0. All prices=0 and all stocks=0, so every slot is soldout until it is configured.
- Outputs are registered; each pulse is exactly one cycle.
- A deposit in cycle n is reflected on balance in cycle n+1.
- For selected in cycle n:
  - CHECK in n+1.
  - vend in n+2.
  - refund in n+3, if change is due.
  - soldout or short pulses in n+2, with state=CREDIT in n+2.
- cancel in cycle n: refund with change=balance in n+2 (CHANGE state), IDLE in n+3.
- A cfg_we write in cycle n is visible to a CHECK from cycle n+1.
- rst mid-transaction discards the balance with no refund pulse; the table is cleared.

## Structure
- Package vm_pkg holds the state encodings (localparams) and the default parameter values. It is shared with the older controller's bench.
- Sub-module vm_slot_table holds NSLOT×(VAL_W+STOCK_W) registers. It has a write port (cfg), a decrement port (dec, slot), and a combinational read of price/stock for the latched slot.
- The top level holds the FSM, the balance register, the overflow detector and the output registers.

## Test plan
- Reset, then configure slot 2 with price=150, stock=1 → exit MAINT. Deposit 100, 100, select 2 → vend with product=2 at n+2, refund change=50 at n+3, stock[2]=0.
- Repeat select 2 with balance 200 → soldout pulse, balance stays 200. Then cancel → refund change=200, IDLE.
- Slot 3 price=300, stock=5, deposit 100, select 3 → short pulse, CREDIT. Deposit 200, select 3 → vend with no refund pulse, IDLE.
- Select code 9 with NSLOT=8 → soldout. Deposit 1000 then 100 at VAL_W=10 → reject, balance=1000.
- Assert selected and cancel in the same CREDIT cycle → cancel wins, refund full balance.
- Assert rst during VEND → next cycle state=IDLE, balance=0, no vend/refund pulses, all stocks=0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine constants: FSM state codes and default sizes.
// Also used by the single-product controller's bench, so keep encodings stable.
package vm_pkg;

   localparam int VAL_W_DEF   = 10;
   localparam int SEL_W_DEF   = 5;
   localparam int NSLOT_DEF   = 8;
   localparam int STOCK_W_DEF = 4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CREDIT = 3'd1;
   localparam logic [2:0] ST_CHECK  = 3'd2;
   localparam logic [2:0] ST_VEND   = 3'd3;
   localparam logic [2:0] ST_CHANGE = 3'd4;
   localparam logic [2:0] ST_MAINT  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_CREDIT = ST_CREDIT,
      S_CHECK  = ST_CHECK,
      S_VEND   = ST_VEND,
      S_CHANGE = ST_CHANGE,
      S_MAINT  = ST_MAINT
   } state_e;

endpackage

// File: rtl/vm_multi_if.sv
// Front-end/actuator bundle of the multi-slot vending controller.
// master = coin/keypad/maintenance side, slave = the controller.
interface vm_multi_if #(
   parameter int VAL_W   = 10,
   parameter int SEL_W   = 5,
   parameter int STOCK_W = 4
);
   logic [VAL_W-1:0]   deposit;
   logic               deposited;
   logic [SEL_W-1:0]   select;
   logic               selected;
   logic               cancel;
   logic               maintenance;
   logic               cfg_we;
   logic [SEL_W-1:0]   cfg_slot;
   logic [VAL_W-1:0]   cfg_price;
   logic [STOCK_W-1:0] cfg_stock;

   logic [SEL_W-1:0]   product;
   logic               vend;
   logic [VAL_W-1:0]   balance;
   logic               refund;
   logic [VAL_W-1:0]   change;
   logic               reject;
   logic               soldout;
   logic               short;
   logic [2:0]         state;

   modport master (
      output deposit, deposited, select, selected, cancel, maintenance,
             cfg_we, cfg_slot, cfg_price, cfg_stock,
      input  product, vend, balance, refund, change, reject, soldout, short, state
   );

   modport slave (
      input  deposit, deposited, select, selected, cancel, maintenance,
             cfg_we, cfg_slot, cfg_price, cfg_stock,
      output product, vend, balance, refund, change, reject, soldout, short, state
   );
endinterface

// File: rtl/vm_slot_table.sv
// Per-slot price/stock registers: write port, saturating decrement port, comb read.
// Writes and decrements land on the next edge; out-of-range slots read as empty.
module vm_slot_table #(
   parameter int VAL_W   = 10,
   parameter int SEL_W   = 5,
   parameter int NSLOT   = 8,
   parameter int STOCK_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [SEL_W-1:0]   cfg_slot,
   input  logic [VAL_W-1:0]   cfg_price,
   input  logic [STOCK_W-1:0] cfg_stock,
   input  logic               dec,
   input  logic [SEL_W-1:0]   slot,
   output logic               slot_ok,
   output logic [VAL_W-1:0]   price,
   output logic [STOCK_W-1:0] stock
);
   localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   logic [VAL_W-1:0]   price_q [NSLOT];
   logic [VAL_W-1:0]   price_d [NSLOT];
   logic [STOCK_W-1:0] stock_q [NSLOT];
   logic [STOCK_W-1:0] stock_d [NSLOT];

   logic               cfg_ok;
   logic [IDX_W-1:0]   cfg_idx;
   logic [IDX_W-1:0]   rd_idx;

   always_comb begin
      cfg_ok  = int'(cfg_slot) < NSLOT;
      cfg_idx = cfg_slot[IDX_W-1:0];
      slot_ok = int'(slot) < NSLOT;
      rd_idx  = slot[IDX_W-1:0];
      price   = slot_ok ? price_q[rd_idx] : '0;
      stock   = slot_ok ? stock_q[rd_idx] : '0;
   end

   // Config writes and vend decrements never coincide (MAINT vs CHECK), cfg wins anyway.
   always_comb begin
      price_d = price_q;
      stock_d = stock_q;
      if (cfg_we && cfg_ok) begin
         price_d[cfg_idx] = cfg_price;
         stock_d[cfg_idx] = cfg_stock;
      end else if (dec && slot_ok && stock_q[rd_idx] != '0) begin
         stock_d[rd_idx] = stock_q[rd_idx] - STOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSLOT; i++) begin
            price_q[i] <= '0;
            stock_q[i] <= '0;
         end
      end else begin
         price_q <= price_d;
         stock_q <= stock_d;
      end
   end
endmodule

// File: rtl/vm_multi.sv
// Multi-slot vending controller: credit accumulation, select check, vend, change return.
// All outputs registered; select->vend 2 cycles, pulses one cycle, no stalls (strobes only).
module vm_multi
   import vm_pkg::*;
#(
   parameter int VAL_W   = VAL_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int NSLOT   = NSLOT_DEF,
   parameter int STOCK_W = STOCK_W_DEF
) (
   input logic       clk,
   input logic       rst,
   vm_multi_if.slave bus
);
   state_e             state_q, state_d;
   logic [VAL_W-1:0]   balance_q, balance_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   product_q, product_d;
   logic [VAL_W-1:0]   change_q, change_d;
   logic               vend_q, vend_d;
   logic               refund_q, refund_d;
   logic               reject_q, reject_d;
   logic               soldout_q, soldout_d;
   logic               short_q, short_d;

   logic               tbl_we;
   logic               tbl_dec;
   logic               tbl_ok;
   logic [VAL_W-1:0]   tbl_price;
   logic [STOCK_W-1:0] tbl_stock;
   logic [VAL_W:0]     sum;

   assign tbl_we = bus.cfg_we && (state_q == S_MAINT);

   vm_slot_table #(
      .VAL_W   (VAL_W),
      .SEL_W   (SEL_W),
      .NSLOT   (NSLOT),
      .STOCK_W (STOCK_W)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (tbl_we),
      .cfg_slot  (bus.cfg_slot),
      .cfg_price (bus.cfg_price),
      .cfg_stock (bus.cfg_stock),
      .dec       (tbl_dec),
      .slot      (sel_q),
      .slot_ok   (tbl_ok),
      .price     (tbl_price),
      .stock     (tbl_stock)
   );

   always_comb begin
      state_d   = state_q;
      balance_d = balance_q;
      sel_d     = sel_q;
      product_d = product_q;
      change_d  = change_q;
      vend_d    = 1'b0;
      refund_d  = 1'b0;
      reject_d  = 1'b0;
      soldout_d = 1'b0;
      short_d   = 1'b0;
      tbl_dec   = 1'b0;
      sum       = {1'b0, balance_q} + {1'b0, bus.deposit};

      case (state_q)
         S_IDLE: begin
            balance_d = '0;
            if (bus.maintenance) begin
               state_d  = S_MAINT;
               reject_d = bus.deposited;
            end else if (bus.deposited) begin
               balance_d = bus.deposit;
               state_d   = S_CREDIT;
            end
         end
         S_CREDIT: begin
            // A deposit losing to cancel/select is refused rather than silently swallowed.
            if (bus.cancel) begin
               state_d  = S_CHANGE;
               reject_d = bus.deposited;
            end else if (bus.selected) begin
               sel_d    = bus.select;
               state_d  = S_CHECK;
               reject_d = bus.deposited;
            end else if (bus.deposited) begin
               if (sum[VAL_W]) reject_d  = 1'b1;
               else            balance_d = sum[VAL_W-1:0];
            end
         end
         S_CHECK: begin
            reject_d = bus.deposited;
            if (!tbl_ok || tbl_stock == '0) begin
               soldout_d = 1'b1;
               state_d   = S_CREDIT;
            end else if (balance_q < tbl_price) begin
               short_d = 1'b1;
               state_d = S_CREDIT;
            end else begin
               balance_d = balance_q - tbl_price;
               tbl_dec   = 1'b1;
               vend_d    = 1'b1;
               product_d = sel_q;
               state_d   = S_VEND;
            end
         end
         S_VEND: begin
            reject_d = bus.deposited;
            if (balance_q != '0) begin
               state_d   = S_CHANGE;
               refund_d  = 1'b1;
               change_d  = balance_q;
               balance_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHANGE: begin
            // From VEND the refund pulse is issued on entry; from cancel it follows one cycle later.
            reject_d = bus.deposited;
            if (refund_q) begin
               state_d = S_IDLE;
            end else begin
               refund_d  = 1'b1;
               change_d  = balance_q;
               balance_d = '0;
            end
         end
         S_MAINT: begin
            reject_d = bus.deposited;
            if (!bus.maintenance) state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            balance_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         balance_q <= '0;
         sel_q     <= '0;
         product_q <= '0;
         change_q  <= '0;
         vend_q    <= 1'b0;
         refund_q  <= 1'b0;
         reject_q  <= 1'b0;
         soldout_q <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         balance_q <= balance_d;
         sel_q     <= sel_d;
         product_q <= product_d;
         change_q  <= change_d;
         vend_q    <= vend_d;
         refund_q  <= refund_d;
         reject_q  <= reject_d;
         soldout_q <= soldout_d;
         short_q   <= short_d;
      end
   end

   assign bus.product = product_q;
   assign bus.vend    = vend_q;
   assign bus.balance = balance_q;
   assign bus.refund  = refund_q;
   assign bus.change  = change_q;
   assign bus.reject  = reject_q;
   assign bus.soldout = soldout_q;
   assign bus.short   = short_q;
   assign bus.state   = state_q;
endmodule

// File: tb/tb_vm_multi.sv
// Directed bench: each user action predicts its per-cycle outcome into a scoreboard keyed by cycle.
module tb_vm_multi;
   localparam int VW = 10, SW = 5, NS = 8, STW = 4;
   localparam int MAXV = (1 << VW) - 1;
   localparam int I_IDLE = 0, I_CREDIT = 1, I_CHECK = 2, I_VEND = 3, I_CHANGE = 4, I_MAINT = 5;
   localparam int K_VEND = 0, K_REFUND = 1, K_REJECT = 2, K_SOLDOUT = 3, K_SHORT = 4;

   typedef struct {
      int st;
      int bal;
      bit vend;
      int product;
      bit refund;
      int change;
      bit reject;
      bit soldout;
      bit short_p;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 0;
   int   cur_st = 0;
   int   cur_bal = 0;

   // Transaction-level model of the machine as seen between user actions.
   int   m_st = I_IDLE;
   int   m_bal = 0;
   int   m_price [NS];
   int   m_stock [NS];
   exp_t exp_q [int];

   vm_multi_if #(.VAL_W(VW), .SEL_W(SW), .STOCK_W(STW)) bus ();

   vm_multi #(.VAL_W(VW), .SEL_W(SW), .NSLOT(NS), .STOCK_W(STW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         failures++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e.st = -1; e.bal = -1; e.vend = 0; e.product = 0; e.refund = 0;
      e.change = 0; e.reject = 0; e.soldout = 0; e.short_p = 0;
      return e;
   endfunction

   function automatic void sched(input int c, input int st, input int bal);
      exp_t e = exp_q.exists(c) ? exp_q[c] : blank();
      e.st = st;
      e.bal = bal;
      exp_q[c] = e;
   endfunction

   function automatic void mark(input int c, input int kind, input int val);
      exp_t e = exp_q.exists(c) ? exp_q[c] : blank();
      case (kind)
         K_VEND:    begin e.vend = 1; e.product = val; end
         K_REFUND:  begin e.refund = 1; e.change = val; end
         K_REJECT:  e.reject = 1;
         K_SOLDOUT: e.soldout = 1;
         default:   e.short_p = 1;
      endcase
      exp_q[c] = e;
   endfunction

   always @(negedge clk) begin : compare
      exp_t e;
      if (chk_en) begin
         e = exp_q.exists(cyc) ? exp_q[cyc] : blank();
         if (exp_q.exists(cyc)) exp_q.delete(cyc);
         if (e.st >= 0)  cur_st = e.st;
         if (e.bal >= 0) cur_bal = e.bal;
         check("state",   32'(bus.state),   cur_st);
         check("balance", 32'(bus.balance), cur_bal);
         check("vend",    32'(bus.vend),    int'(e.vend));
         check("refund",  32'(bus.refund),  int'(e.refund));
         check("reject",  32'(bus.reject),  int'(e.reject));
         check("soldout", 32'(bus.soldout), int'(e.soldout));
         check("short",   32'(bus.short),   int'(e.short_p));
         if (e.vend)   check("product", 32'(bus.product), e.product);
         if (e.refund) check("change",  32'(bus.change),  e.change);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_deposit(input int v);
      int n = cyc;
      bus.deposit = v[VW-1:0];
      bus.deposited = 1'b1;
      if (m_st == I_IDLE) begin
         m_bal = v;
         m_st  = I_CREDIT;
      end else if (m_st == I_CREDIT) begin
         if (m_bal + v > MAXV) mark(n + 1, K_REJECT, 0);
         else                  m_bal += v;
      end else begin
         mark(n + 1, K_REJECT, 0);
      end
      sched(n + 1, m_st, m_bal);
      tick();
      bus.deposited = 1'b0;
   endtask

   task automatic do_reset();
      int n = cyc;
      int late [$];
      rst = 1'b1;
      foreach (exp_q[k]) if (k > n) late.push_back(k);
      foreach (late[i]) exp_q.delete(late[i]);
      sched(n + 1, I_IDLE, 0);
      for (int i = 0; i < NS; i++) begin
         m_price[i] = 0;
         m_stock[i] = 0;
      end
      m_bal = 0;
      m_st  = I_IDLE;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_select(input int s, input bit dep_in_check, input bit rst_in_vend);
      int n = cyc;
      int done;
      bus.select = s[SW-1:0];
      bus.selected = 1'b1;
      sched(n + 1, I_CHECK, m_bal);
      if (s >= NS || m_stock[s] == 0) begin
         sched(n + 2, I_CREDIT, m_bal);
         mark(n + 2, K_SOLDOUT, 0);
         done = n + 2;
      end else if (m_bal < m_price[s]) begin
         sched(n + 2, I_CREDIT, m_bal);
         mark(n + 2, K_SHORT, 0);
         done = n + 2;
      end else begin
         m_bal -= m_price[s];
         m_stock[s]--;
         sched(n + 2, I_VEND, m_bal);
         mark(n + 2, K_VEND, s);
         if (m_bal != 0) begin
            sched(n + 3, I_CHANGE, 0);
            mark(n + 3, K_REFUND, m_bal);
            sched(n + 4, I_IDLE, 0);
            done = n + 4;
         end else begin
            sched(n + 3, I_IDLE, 0);
            done = n + 3;
         end
         m_bal = 0;
         m_st  = I_IDLE;
      end
      tick();
      bus.selected = 1'b0;
      if (dep_in_check) begin
         bus.deposit = 10'd7;
         bus.deposited = 1'b1;
         mark(n + 2, K_REJECT, 0);
      end
      tick();
      bus.deposited = 1'b0;
      if (rst_in_vend) do_reset();
      else while (cyc < done) tick();
   endtask

   task automatic do_cancel(input bit with_sel);
      int n = cyc;
      int b = m_bal;
      bus.cancel = 1'b1;
      if (with_sel) begin
         bus.select = 5'd2;
         bus.selected = 1'b1;
      end
      sched(n + 1, I_CHANGE, b);
      sched(n + 2, I_CHANGE, 0);
      mark(n + 2, K_REFUND, b);
      sched(n + 3, I_IDLE, 0);
      m_bal = 0;
      m_st  = I_IDLE;
      tick();
      bus.cancel = 1'b0;
      bus.selected = 1'b0;
      tick();
      tick();
   endtask

   task automatic idle_noise();
      int n = cyc;
      bus.selected = 1'b1;
      bus.select = 5'd2;
      bus.cancel = 1'b1;
      sched(n + 1, I_IDLE, 0);
      tick();
      bus.selected = 1'b0;
      bus.cancel = 1'b0;
   endtask

   task automatic maint_on();
      bus.maintenance = 1'b1;
      m_st = I_MAINT;
      sched(cyc + 1, I_MAINT, 0);
      tick();
   endtask

   task automatic cfg_write(input int slot, input int price, input int stock);
      bus.cfg_we = 1'b1;
      bus.cfg_slot = slot[SW-1:0];
      bus.cfg_price = price[VW-1:0];
      bus.cfg_stock = stock[STW-1:0];
      if (slot < NS) begin
         m_price[slot] = price;
         m_stock[slot] = stock;
      end
      sched(cyc + 1, I_MAINT, 0);
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic maint_off();
      bus.maintenance = 1'b0;
      m_st = I_IDLE;
      sched(cyc + 1, I_IDLE, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.deposit = '0;  bus.deposited = 1'b0;
      bus.select = '0;   bus.selected = 1'b0;
      bus.cancel = 1'b0; bus.maintenance = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_slot = '0;
      bus.cfg_price = '0; bus.cfg_stock = '0;
      for (int i = 0; i < NS; i++) begin
         m_price[i] = 0;
         m_stock[i] = 0;
      end
      repeat (2) tick();
      chk_en = 1;
      check("reset state",   32'(bus.state),   0);
      check("reset balance", 32'(bus.balance), 0);
      check("reset product", 32'(bus.product), 0);
      check("reset change",  32'(bus.change),  0);
      rst = 1'b0;
      tick();

      idle_noise();
      maint_on();
      cfg_write(2, 150, 1);
      cfg_write(9, 77, 7);
      maint_off();
      do_deposit(100);
      do_deposit(100);
      do_select(2, 0, 0);
      check("model stock2 after vend", 32'(m_stock[2]), 0);
      check("state after vend+change", 32'(bus.state), 0);

      do_deposit(100);
      do_deposit(100);
      do_select(2, 0, 0);
      check("balance after soldout", 32'(bus.balance), 200);
      check("state after soldout", 32'(bus.state), 1);
      do_cancel(0);
      check("state after cancel", 32'(bus.state), 0);

      maint_on();
      do_deposit(5);
      cfg_write(3, 300, 5);
      maint_off();
      do_deposit(100);
      do_select(3, 0, 0);
      check("state after short", 32'(bus.state), 1);
      check("balance after short", 32'(bus.balance), 100);
      do_deposit(200);
      do_select(3, 0, 0);
      check("model stock3 after exact vend", 32'(m_stock[3]), 4);

      do_deposit(50);
      do_select(9, 0, 0);
      do_cancel(0);
      do_deposit(1000);
      do_deposit(100);
      check("balance after overflow", 32'(bus.balance), 1000);
      do_deposit(23);
      check("balance at max", 32'(bus.balance), 1023);
      do_deposit(1);
      do_cancel(1);

      do_deposit(300);
      do_select(3, 1, 0);

      do_deposit(400);
      do_select(3, 0, 1);
      check("state after reset in vend", 32'(bus.state), 0);
      check("balance after reset in vend", 32'(bus.balance), 0);
      do_deposit(400);
      do_select(3, 0, 0);
      do_cancel(0);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
